// File: rtl/clk_mon_pkg.sv
// ============================================================================
// clk_mon_pkg : shared types and default constants for clk_ratio_monitor
// Revision    : 1.0
// ============================================================================
`default_nettype none

package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int DEF_EXP_HALF = 4;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_TIMEOUT  = 8;
  localparam int ERR_MAX      = 255;

endpackage

`default_nettype wire

// File: rtl/clk_ratio_monitor_edge_sync.sv
// ============================================================================
// edge_sync : two-flop sampler of the divided clock with an any-edge detector
// Revision  : 1.0
// ============================================================================
`default_nettype none

module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic edge_det
);

  logic s0;
  logic s1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= din;
      s1 <= s0;
    end
  end

  assign edge_det = s0 ^ s1;

endmodule

`default_nettype wire

// File: rtl/clk_ratio_monitor.sv
// ============================================================================
// clk_ratio_monitor : measures each half-period of a divided clock against an
//                     expected ratio; reports lock, error pulses, error count
// Revision          : 1.0
// ============================================================================
`default_nettype none

module clk_ratio_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int EXP_HALF = DEF_EXP_HALF,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_clk_in,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_count
);

  localparam int               GOOD_W    = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] EXP_C     = CNT_W'(EXP_HALF);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [GOOD_W-1:0] LOCK_C   = GOOD_W'(LOCK_CNT);
  localparam logic [7:0]       ERR_MAX_C = 8'(ERR_MAX);

  logic              edge_det;
  state_t            state, state_n;
  logic [CNT_W-1:0]  run_cnt, run_cnt_n;
  logic [GOOD_W-1:0] good_cnt, good_n;
  logic [CNT_W-1:0]  half_n;
  logic              mv_n;
  logic              locked_n;
  logic              err_n;
  logic [7:0]        errc_n;
  logic [7:0]        errc_inc;

  edge_sync u_edge_sync (
    .clk      (clk),
    .reset    (reset),
    .din      (div_clk_in),
    .edge_det (edge_det)
  );

  assign errc_inc = (err_count == ERR_MAX_C) ? err_count : err_count + 8'd1;

  always_comb begin
    state_n   = state;
    run_cnt_n = edge_det ? CNT_W'(1)
                         : ((run_cnt == CNT_MAX) ? run_cnt : run_cnt + 1'b1);
    good_n    = good_cnt;
    half_n    = half_period;
    mv_n      = 1'b0;
    locked_n  = locked;
    err_n     = 1'b0;
    errc_n    = err_count;

    unique case (state)
      IDLE: begin
        if (edge_det) state_n = MEASURE;
      end
      MEASURE, LOCKED: begin
        if (edge_det) begin
          // An edge landing on the timeout count is still a measurement.
          half_n = run_cnt;
          mv_n   = 1'b1;
          if (run_cnt == EXP_C) begin
            good_n = (good_cnt == LOCK_C) ? good_cnt : good_cnt + 1'b1;
            if (good_n == LOCK_C) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
            end
          end else begin
            err_n    = 1'b1;
            errc_n   = errc_inc;
            good_n   = '0;
            state_n  = MEASURE;
            locked_n = 1'b0;
          end
        end else if (run_cnt == TIMEOUT_C) begin
          err_n    = 1'b1;
          errc_n   = errc_inc;
          good_n   = '0;
          locked_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      run_cnt     <= '0;
      good_cnt    <= '0;
      half_period <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_n;
      run_cnt     <= run_cnt_n;
      good_cnt    <= good_n;
      half_period <= half_n;
      meas_valid  <= mv_n;
      locked      <= locked_n;
      err         <= err_n;
      err_count   <= errc_n;
    end
  end

endmodule

`default_nettype wire

// File: doc/clk_ratio_monitor.md
Name: clk_ratio_monitor

Overview:
Receiving-end checker for the clock divider.
- Samples a divided clock (div_clk_in, generated synchronously from clk) and measures every half-period in clk cycles.
- Compares each measurement against the expected ratio and reports lock, error pulses and a saturating error count.
- Sits beside the divider in clock-generation logic as a run-time health monitor.

Parameters:
CNT_W, 8, width of the half-period counter and the half_period output
EXP_HALF, 4, expected half-period in clk cycles (4 corresponds to divide-by-8)
LOCK_CNT, 4, consecutive matching half-periods required to assert locked
TIMEOUT, 8, clk cycles without an input edge before a stuck error is raised (must be greater than EXP_HALF)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-low reset (reset==0 clears the block on the next posedge)
div_clk_in  input  1  divided clock under test, synchronous to clk
half_period  output  CNT_W  most recent measured half-period, in clk cycles
meas_valid  output  1  one-cycle pulse when half_period updates
locked  output  1  high while ratio is confirmed
err  output  1  one-cycle pulse on mismatch or timeout
err_count  output  8  error counter, saturates at 255

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; s0, s1, run_cnt, good_cnt cleared; half_period=0, meas_valid=0, locked=0, err=0, err_count=0. Reset overrides everything, including mid-measurement and locked states.
- Sampling: s0<=div_clk_in; s1<=s0; edge = s0 ^ s1 (either polarity).
- Latency: an input transition before posedge k updates outputs at posedge k+1.
- run_cnt: on an edge posedge, load 1. Otherwise increment, saturating at all-ones.
  - With the input toggling every N posedges, run_cnt equals N at the next edge posedge.
- States are IDLE, MEASURE and LOCKED.
- IDLE:
  - edge: go to MEASURE, run_cnt<=1, no measurement reported.
  - no edge: run_cnt counts but no timeout check.
- MEASURE / LOCKED on edge:
  - half_period<=run_cnt; meas_valid<=1.
  - Match (run_cnt==EXP_HALF): good_cnt++ (saturating at LOCK_CNT). When good_cnt reaches LOCK_CNT, state=LOCKED and locked<=1 on that same posedge.
  - Mismatch: err<=1; err_count++ (saturating); good_cnt<=0; state=MEASURE; locked<=0.
- MEASURE / LOCKED with no edge and run_cnt==TIMEOUT:
  - err<=1; err_count++ (saturating); good_cnt<=0; locked<=0; state=IDLE.
  - half_period holds its value.
- Simultaneous edge and timeout value: the edge has priority and is a normal measurement, judged by the match rule.
- meas_valid and err are single-cycle pulses, deasserted on the following posedge.
- All outputs are registered; no combinational path from input to output.

Decomposition:
- Package clk_mon_pkg holds:
  - state enum typedef {IDLE, MEASURE, LOCKED};
  - default constants for EXP_HALF, LOCK_CNT, TIMEOUT;
  - ERR_MAX=255.
- One natural sub-module: edge_sync, containing the s0/s1 flops and the XOR edge output, with the same clk/reset.

Test Plan:
- Nominal ratio: release reset; drive div_clk_in toggling every 4 posedges (divide-by-8) -> meas_valid pulses every 4 cycles with half_period=4; locked=1 at the posedge of the 4th measurement (5th detected edge); err never asserts; err_count=0.
- Glitch period: while locked, stretch one half-period to 5 -> half_period=5, err pulse, err_count=1, locked=0 the same posedge; locked returns after 4 further half-periods of 4.
- Stuck input: while locked, hold div_clk_in constant -> err pulse exactly when run_cnt hits 8 (8 posedges after the last edge posedge), locked=0, state=IDLE; the next edge produces no meas_valid and the one after it reports half_period=4.
- Reset mid-operation: drive reset=0 for one posedge while locked with err_count=3 -> next posedge all outputs are 0 and state=IDLE; remeasurement restarts cleanly.
- Saturation: inject 300 mismatched half-periods (length 2) -> err_count climbs and holds at 255, err still pulses per mismatch, no wrap to 0.
- Edge/timeout tie: with TIMEOUT=8, provide a half-period of exactly 8 -> counted as a mismatch (single err, half_period=8, state=MEASURE), not a timeout.
